// File: rtl/demux_1to4_64_buf_if.sv
// Bus bundle for the 1-to-4 buffered demux.
//   upstream   : i_valid, i_select, i_data  -> o_ready
//   downstream : o_valid[3:0], o_data_0..3  <- i_ready[3:0]
//   status     : o_count (words accepted since reset)
// slave modport faces the demux and master modport faces the environment.
interface demux_1to4_64_buf_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
);
  logic              i_valid;
  logic [1:0]        i_select;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic [3:0]        o_valid;
  logic [DATA_W-1:0] o_data_0;
  logic [DATA_W-1:0] o_data_1;
  logic [DATA_W-1:0] o_data_2;
  logic [DATA_W-1:0] o_data_3;
  logic [3:0]        i_ready;
  logic [CNT_W-1:0]  o_count;

  modport slave (
    input  i_valid, i_select, i_data, i_ready,
    output o_ready, o_valid, o_data_0, o_data_1, o_data_2, o_data_3, o_count
  );

  modport master (
    output i_valid, i_select, i_data, i_ready,
    input  o_ready, o_valid, o_data_0, o_data_1, o_data_2, o_data_3, o_count
  );
endinterface

// File: rtl/demux_1to4_64_buf.sv
// 1-to-4 demultiplexer with a one-entry holding register per output port.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : demux_1to4_64_buf_if.slave (upstream handshake, four downstream
//             valid/ready ports, accepted-word counter)
// o_ready is combinational and depends only on the selected port, so a full
// port that is draining this cycle can take a new word with no bubble.
module demux_1to4_64_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  demux_1to4_64_buf_if.slave  bus
);

  localparam int unsigned N_PORTS = 4;

  logic [N_PORTS-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [N_PORTS];
  logic [CNT_W-1:0]   count_q;

  logic               in_fire;
  logic [N_PORTS-1:0] out_fire;

  // Accept when the selected slot is empty or being drained this cycle.
  assign bus.o_ready = !valid_q[bus.i_select] || bus.i_ready[bus.i_select];
  assign in_fire     = bus.i_valid && bus.o_ready;
  assign out_fire    = valid_q & bus.i_ready;

  // Per-port holding registers; a load wins over a drain on the same port.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (in_fire && (bus.i_select == 2'(k))) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= bus.i_data;
        end else if (out_fire[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (in_fire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_data_0 = data_q[0];
  assign bus.o_data_1 = data_q[1];
  assign bus.o_data_2 = data_q[2];
  assign bus.o_data_3 = data_q[3];
  assign bus.o_count  = count_q;

endmodule

// File: tb/tb_demux_1to4_64_buf.sv
// Directed testbench for demux_1to4_64_buf.
module tb_demux_1to4_64_buf;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  demux_1to4_64_buf_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  demux_1to4_64_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [63:0] d,
                       input logic [3:0] rdy);
    bus.i_valid  = v;
    bus.i_select = sel;
    bus.i_data   = d;
    bus.i_ready  = rdy;
    #1;
  endtask

  logic [63:0] w;
  logic [63:0] c [4];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    step();
    step();
    check("rst_valid", 64'(bus.o_valid), 64'h0);
    check("rst_d0", bus.o_data_0, 64'h0);
    check("rst_d3", bus.o_data_3, 64'h0);
    check("rst_count", 64'(bus.o_count), 64'h0);

    // First accept to port 2.
    rst_n = 1'b1;
    w = 64'hDEAD_BEEF_0000_0002;
    drive(1'b1, 2'd2, w, 4'b0000);
    check("first_ready", 64'(bus.o_ready), 64'h1);
    step();
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    check("first_valid", 64'(bus.o_valid), 64'h4);
    check("first_d2", bus.o_data_2, w);
    check("first_count", 64'(bus.o_count), 64'd1);
    check("first_ready_sel0", 64'(bus.o_ready), 64'h1);
    drive(1'b0, 2'd2, 64'd0, 4'b0000);
    check("full_ready_sel2", 64'(bus.o_ready), 64'h0);

    // Port 1 full and stalled: no accepts for 3 cycles.
    drive(1'b1, 2'd1, 64'h1111_0000_0000_0001, 4'b0000);
    step();
    check("p1_valid", 64'(bus.o_valid), 64'h6);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 64'h2222_0000_0000_0002, 4'b0000);
      check($sformatf("stall_ready%0d", i), 64'(bus.o_ready), 64'h0);
      step();
      check($sformatf("stall_d1_%0d", i), bus.o_data_1, 64'h1111_0000_0000_0001);
      check($sformatf("stall_cnt%0d", i), 64'(bus.o_count), 64'd2);
    end

    // Port 3: load A, then replace with B while A drains.
    drive(1'b1, 2'd3, 64'hAAAA_AAAA_AAAA_AAAA, 4'b0000);
    step();
    check("p3a_count", 64'(bus.o_count), 64'd3);
    drive(1'b1, 2'd3, 64'hBBBB_BBBB_BBBB_BBBB, 4'b1000);
    check("p3b_ready", 64'(bus.o_ready), 64'h1);
    check("p3_consumer_a", bus.o_data_3, 64'hAAAA_AAAA_AAAA_AAAA);
    step();
    check("p3b_valid", 64'(bus.o_valid[3]), 64'h1);
    check("p3b_data", bus.o_data_3, 64'hBBBB_BBBB_BBBB_BBBB);
    check("p3b_count", 64'(bus.o_count), 64'd4);
    c[0] = 64'hC0C0_0000_0000_0000;
    c[1] = 64'hC1C1_0000_0000_0001;
    c[2] = 64'hC2C2_0000_0000_0002;
    c[3] = 64'hC3C3_0000_0000_0003;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, c[i], 4'b1000);
      check($sformatf("burst_ready%0d", i), 64'(bus.o_ready), 64'h1);
      step();
      check($sformatf("burst_d3_%0d", i), bus.o_data_3, c[i]);
    end
    check("burst_count", 64'(bus.o_count), 64'd8);
    drive(1'b0, 2'd0, 64'd0, 4'b1000);
    step();
    check("p3_drained", 64'(bus.o_valid), 64'h6);
    check("p3_data_kept", bus.o_data_3, c[3]);

    // Ports 0 and 2 full; port 2 rejects while port 0 drains.
    drive(1'b0, 2'd0, 64'd0, 4'b0010);
    step();
    check("p1_drained", 64'(bus.o_valid), 64'h4);
    drive(1'b1, 2'd0, 64'h0000_0000_0000_00F0, 4'b0000);
    step();
    check("p0_valid", 64'(bus.o_valid), 64'h5);
    check("p0_count", 64'(bus.o_count), 64'd9);
    drive(1'b1, 2'd2, 64'h5555_5555_5555_5555, 4'b0001);
    check("indep_ready", 64'(bus.o_ready), 64'h0);
    step();
    check("indep_valid", 64'(bus.o_valid), 64'h4);
    check("indep_d2", bus.o_data_2, w);
    check("indep_count", 64'(bus.o_count), 64'd9);

    // Fill all four ports, then reset mid-operation.
    drive(1'b1, 2'd0, 64'h0000_0000_0000_0A00, 4'b0000);
    step();
    drive(1'b1, 2'd1, 64'h0000_0000_0000_0A01, 4'b0000);
    step();
    drive(1'b1, 2'd3, 64'h0000_0000_0000_0A03, 4'b0000);
    step();
    check("all_full", 64'(bus.o_valid), 64'hF);
    check("all_count", 64'(bus.o_count), 64'd12);
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 64'h0000_0000_0000_0BAD, 4'b1111);
    step();
    check("mid_rst_valid", 64'(bus.o_valid), 64'h0);
    check("mid_rst_d0", bus.o_data_0, 64'h0);
    check("mid_rst_d1", bus.o_data_1, 64'h0);
    check("mid_rst_d2", bus.o_data_2, 64'h0);
    check("mid_rst_d3", bus.o_data_3, 64'h0);
    check("mid_rst_count", 64'(bus.o_count), 64'h0);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, w, 4'b0000);
    step();
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    check("post_rst_valid", 64'(bus.o_valid), 64'h4);
    check("post_rst_d2", bus.o_data_2, w);
    check("post_rst_count", 64'(bus.o_count), 64'd1);

    // Counter wrap: bring count to 65535 via port 0 streaming, then one more.
    drive(1'b1, 2'd0, 64'h0000_0000_0000_00CC, 4'b0001);
    for (int i = 0; i < 65534; i++) begin
      step();
    end
    check("cnt_max", 64'(bus.o_count), 64'd65535);
    step();
    check("cnt_wrap", 64'(bus.o_count), 64'd0);
    drive(1'b0, 2'd0, 64'd0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
